// File: rtl/charger_pkg.sv
// Shared encodings for the keypad scanner: FSM states, key codes and the matrix lookup.
// Imported by the scanner, its interface and the bench.
package charger_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_e;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_NONE = 4'd15;

   // '*', '#' and 'D' map to KEY_NONE: they are scanned but never drive an output.
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'd1;
         4'h1:    code = 4'd2;
         4'h2:    code = 4'd3;
         4'h3:    code = KEY_A;
         4'h4:    code = 4'd4;
         4'h5:    code = 4'd5;
         4'h6:    code = 4'd6;
         4'h7:    code = KEY_B;
         4'h8:    code = 4'd7;
         4'h9:    code = 4'd8;
         4'hA:    code = 4'd9;
         4'hB:    code = KEY_C;
         4'hD:    code = 4'd0;
         default: code = KEY_NONE;
      endcase
      return code;
   endfunction

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

   function automatic logic [1:0] first_low_row(input logic [3:0] rows_n);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_n[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the level outputs seen by the charge controller.
// No valid/ready: every output is a clean registered level; the consumer edge-detects.
interface keypad_scanner_if;
   import charger_pkg::*;

   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_value;
   logic        press;
   logic        start;
   logic        clear;
   logic        confirm;
   scan_state_e dbg_state;

   modport master (
      input  row_n,
      output col_n, key_value, press, start, clear, confirm, dbg_state
   );

   modport slave (
      output row_n,
      input  col_n, key_value, press, start, clear, confirm, dbg_state
   );

endinterface

// File: rtl/keypad_sync.sv
// 4-bit two-flop synchronizer for the active-low keypad rows; idles at all-high.
module keypad_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d_n,
   output logic [3:0] q_n
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= d_n;
         sync_q <= meta_q;
      end
   end

   assign q_n = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, driving press/start/clear/confirm levels.
// Optional held-digit auto-repeat is enabled by defining KEY_REPEAT_EN.
module keypad_scanner
   import charger_pkg::*;
#(
   parameter int SCAN_DIV     = 1,
   parameter int DEBOUNCE_CYC = 20,
   parameter int REPEAT_CYC   = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   keypad_scanner_if.master kif
);

   localparam int CNT_MAX = (DEBOUNCE_CYC > REPEAT_CYC) ? DEBOUNCE_CYC : REPEAT_CYC;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam int SW      = $clog2(SCAN_DIV) + 1;

   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] CNT_SAT   = '1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

   logic [3:0] row_s;

   keypad_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_n   (kif.row_n),
      .q_n   (row_s)
   );

   scan_state_e   state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    col_n_q, col_n_d;
   logic [1:0]    col_p1_q, col_p2_q;
   logic [1:0]    row_lat_q, row_lat_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    code_q, code_d;
   logic [3:0]    key_value_q, key_value_d;
   logic          press_q, press_d;
   logic          start_q, start_d;
   logic          clear_q, clear_d;
   logic          confirm_q, confirm_d;
`ifdef KEY_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYC - 1);
   logic [CW-1:0] rep_q, rep_d;
   logic [CW-1:0] rep_inc;
`endif

   logic          sample_valid;
   logic          any_low;
   logic          lat_low;
   logic          low_eff;
   logic [CW-1:0] cnt_inc;
   logic [3:0]    code_now;

   // A row sample reflects the column driven three clocks earlier (column flop
   // plus two sync flops); col_p2_q tracks which column that was.
   assign sample_valid = (col_p2_q == col_q);
   assign any_low      = ~&row_s;
   assign lat_low      = ~row_s[row_lat_q];
   // Samples still in flight from before the freeze do not count as a release.
   assign low_eff      = !sample_valid || lat_low;
   assign cnt_inc      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
   assign code_now     = key_code(row_lat_q, col_q);
`ifdef KEY_REPEAT_EN
   assign rep_inc      = (rep_q == CNT_SAT) ? rep_q : rep_q + 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_lat_d   = row_lat_q;
      slot_d      = slot_q;
      cnt_d       = cnt_q;
      code_d      = code_q;
      key_value_d = key_value_q;
      press_d     = press_q;
      start_d     = start_q;
      clear_d     = clear_q;
      confirm_d   = confirm_q;
`ifdef KEY_REPEAT_EN
      rep_d       = rep_q;
`endif
      unique case (state_q)
         ST_SCAN: begin
            if (slot_q == SLOT_LAST) begin
               slot_d = '0;
               if (any_low) begin
                  state_d   = ST_DEBOUNCE;
                  col_d     = col_p2_q;
                  row_lat_d = first_low_row(row_s);
                  cnt_d     = '0;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               slot_d = slot_q + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (!low_eff) begin
               state_d = ST_SCAN;
               col_d   = col_q + 2'd1;
               slot_d  = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d   = ST_HELD;
               code_d    = code_now;
               start_d   = (code_now == KEY_A);
               clear_d   = (code_now == KEY_B);
               confirm_d = (code_now == KEY_C);
               if (is_digit(code_now)) begin
                  key_value_d = code_now;
                  press_d     = 1'b1;
               end
`ifdef KEY_REPEAT_EN
               rep_d = '0;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_HELD: begin
            if (sample_valid && !lat_low) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
               press_d = is_digit(code_q);
            end else begin
`ifdef KEY_REPEAT_EN
               // One-clock gap gives the controller a fresh rising edge.
               if (is_digit(code_q)) begin
                  if (rep_q == REP_LAST) begin
                     press_d = 1'b0;
                     rep_d   = '0;
                  end else begin
                     press_d = 1'b1;
                     rep_d   = rep_inc;
                  end
               end
`endif
            end
         end
         ST_RELEASE: begin
            if (low_eff) begin
               state_d = ST_HELD;
            end else if (cnt_q == DB_LAST) begin
               state_d   = ST_SCAN;
               col_d     = col_q + 2'd1;
               slot_d    = '0;
               press_d   = 1'b0;
               start_d   = 1'b0;
               clear_d   = 1'b0;
               confirm_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_SCAN;
      endcase
      col_n_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SCAN;
         col_q       <= 2'd0;
         col_n_q     <= 4'b1110;
         col_p1_q    <= 2'd0;
         col_p2_q    <= 2'd0;
         row_lat_q   <= 2'd0;
         slot_q      <= '0;
         cnt_q       <= '0;
         code_q      <= KEY_NONE;
         key_value_q <= 4'd0;
         press_q     <= 1'b0;
         start_q     <= 1'b0;
         clear_q     <= 1'b0;
         confirm_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         col_n_q     <= col_n_d;
         col_p1_q    <= col_q;
         col_p2_q    <= col_p1_q;
         row_lat_q   <= row_lat_d;
         slot_q      <= slot_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         key_value_q <= key_value_d;
         press_q     <= press_d;
         start_q     <= start_d;
         clear_q     <= clear_d;
         confirm_q   <= confirm_d;
`ifdef KEY_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign kif.col_n     = col_n_q;
   assign kif.key_value = key_value_q;
   assign kif.press     = press_q;
   assign kif.start     = start_q;
   assign kif.clear     = clear_q;
   assign kif.confirm   = confirm_q;
   assign kif.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix keypad model, expected-output queue, per-scenario tasks.
module tb_keypad_scanner;
   import charger_pkg::*;

   localparam int DC = 20;
   localparam int RC = 500;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] pressed = '0;
   logic [3:0]  row_model;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  last_digit = 4'd0;
   logic [7:0]  exp_q[$];
   logic [3:0]  prev_out = 4'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   keypad_scanner_if kif ();

   keypad_scanner #(.SCAN_DIV(1), .DEBOUNCE_CYC(DC), .REPEAT_CYC(RC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   // Passive matrix: a held key shorts its row to its column when that column is driven low.
   always_comb begin
      row_model = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kif.col_n[c]) row_model[r] = 1'b0;
   end
   assign kif.row_n = row_model;

   // Scoreboard: every rising output pops one {kind, key_value} entry.
   always @(negedge clk) begin : monitor
      logic [3:0] outs;
      logic [7:0] got;
      logic [7:0] exp_v;
      outs = {kif.confirm, kif.clear, kif.start, kif.press};
      if (rst_n) begin
         checks++;
         if (!$onehot0(outs)) begin
            errors++;
            $display("FAIL onehot outs=%b required at most one high (cyc %0d)", outs, cyc);
         end
         for (int i = 0; i < 4; i++) begin
            if (outs[i] && !prev_out[i]) begin
               got = {4'(i + 1), kif.key_value};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rise got %h required none (cyc %0d)", got, cyc);
               end else begin
                  exp_v = exp_q.pop_front();
                  if (got !== exp_v) begin
                     errors++;
                     $display("FAIL rise_value got %h required %h (cyc %0d)", got, exp_v, cyc);
                  end
               end
            end
         end
      end
      prev_out = outs;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish (cyc %0d)", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic out_sel(input int sel);
      case (sel)
         1:       return kif.press;
         2:       return kif.start;
         3:       return kif.clear;
         default: return kif.confirm;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int r, input int c, input logic v);
      pressed[r*4+c] = v;
   endtask

   task automatic wait_level(input int sel, input logic lvl, input int budget,
                             output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (out_sel(sel) === lvl) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_col(input int c, input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (kif.col_n[c] === 1'b0) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #11;
      checks++;
      if (kif.col_n !== 4'b1110) begin
         errors++; $display("FAIL reset_col_n got %b required 1110", kif.col_n);
      end
      checks++;
      if (kif.key_value !== 4'd0) begin
         errors++; $display("FAIL reset_key_value got %0d required 0", kif.key_value);
      end
      checks++;
      if ({kif.press, kif.start, kif.clear, kif.confirm} !== 4'b0000) begin
         errors++; $display("FAIL reset_outputs got %b required 0000",
                            {kif.press, kif.start, kif.clear, kif.confirm});
      end
      checks++;
      if (kif.dbg_state !== ST_SCAN) begin
         errors++; $display("FAIL reset_state got %0d required %0d", kif.dbg_state, ST_SCAN);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (kif.col_n !== 4'b1101) begin
         errors++; $display("FAIL reset_first_rotate got %b required 1101", kif.col_n);
      end
   endtask

   task automatic test_clean_press();
      int t0, mc, at, rel;
      bit ok;
      step(1);
      set_key(2, 0, 1'b1);
      t0 = cyc;
      exp_q.push_back({4'd1, 4'd7});
      wait_col(0, 8, mc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clean_col_seen got 0 required 1"); end
      wait_level(1, 1'b1, 60, at, ok);
      checks++;
      if (!ok || at != mc + 3 + DC) begin
         errors++; $display("FAIL clean_rise_cyc got %0d required %0d", at, mc + 3 + DC);
      end
      checks++;
      if (kif.key_value !== 4'd7) begin
         errors++; $display("FAIL clean_key_value got %0d required 7", kif.key_value);
      end
      step(100 - (cyc - t0));
      set_key(2, 0, 1'b0);
      rel = cyc;
      wait_level(1, 1'b0, 60, at, ok);
      checks++;
      if (!ok || at != rel + 3 + DC) begin
         errors++; $display("FAIL clean_fall_cyc got %0d required %0d", at, rel + 3 + DC);
      end
      step(10);
      checks++;
      if (kif.key_value !== 4'd7) begin
         errors++; $display("FAIL clean_value_kept got %0d required 7", kif.key_value);
      end
      last_digit = 4'd7;
   endtask

   task automatic test_bounce();
      int t0, at, rf;
      bit ok;
      step(1);
      set_key(0, 2, 1'b1);
      step(5);
      set_key(0, 2, 1'b0);
      step(2);
      exp_q.push_back({4'd1, 4'd3});
      set_key(0, 2, 1'b1);
      t0 = cyc;
      wait_level(1, 1'b1, 60, at, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bounce_press got 0 required 1"); end
      checks++;
      if (kif.key_value !== 4'd3) begin
         errors++; $display("FAIL bounce_key_value got %0d required 3", kif.key_value);
      end
      step(40 - (cyc - t0));
      set_key(0, 2, 1'b0);
      step(5);
      set_key(0, 2, 1'b1);
      step(3);
      set_key(0, 2, 1'b0);
      rf = cyc;
      wait_level(1, 1'b0, 60, at, ok);
      checks++;
      if (!ok || at != rf + 3 + DC) begin
         errors++; $display("FAIL bounce_fall_cyc got %0d required %0d", at, rf + 3 + DC);
      end
      step(10);
      last_digit = 4'd3;
   endtask

   task automatic test_function_keys();
      int key_r[3] = '{0, 1, 2};
      int dead_r[3] = '{3, 3, 3};
      int dead_c[3] = '{3, 0, 2};
      int t0, at;
      bit ok;
      for (int k = 0; k < 3; k++) begin
         step(1);
         set_key(key_r[k], 3, 1'b1);
         t0 = cyc;
         exp_q.push_back({4'(k + 2), last_digit});
         wait_level(k + 2, 1'b1, 60, at, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL func_rise_%0d got 0 required 1", k); end
         step(50 - (cyc - t0));
         set_key(key_r[k], 3, 1'b0);
         wait_level(k + 2, 1'b0, 60, at, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL func_fall_%0d got 1 required 0", k); end
         step(5);
      end
      for (int k = 0; k < 3; k++) begin
         set_key(dead_r[k], dead_c[k], 1'b1);
         step(50);
         set_key(dead_r[k], dead_c[k], 1'b0);
         step(30);
         checks++;
         if ({kif.press, kif.start, kif.clear, kif.confirm, kif.key_value} !==
             {4'b0000, last_digit}) begin
            errors++;
            $display("FAIL dead_key_%0d got %b/%0d required 0000/%0d", k,
                     {kif.press, kif.start, kif.clear, kif.confirm}, kif.key_value, last_digit);
         end
      end
   endtask

   task automatic test_two_keys();
      int at;
      bit ok;
      step(1);
      set_key(0, 0, 1'b1);
      exp_q.push_back({4'd1, 4'd1});
      wait_level(1, 1'b1, 60, at, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL two_first_press got 0 required 1"); end
      step(5);
      set_key(2, 2, 1'b1);
      step(40);
      checks++;
      if ({kif.press, kif.key_value} !== {1'b1, 4'd1}) begin
         errors++; $display("FAIL two_held got %b/%0d required 1/1", kif.press, kif.key_value);
      end
      set_key(0, 0, 1'b0);
      set_key(2, 2, 1'b0);
      wait_level(1, 1'b0, 60, at, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL two_release got 1 required 0"); end
      step(60);
      checks++;
      if ({kif.press, kif.key_value} !== {1'b0, 4'd1}) begin
         errors++; $display("FAIL two_after got %b/%0d required 0/1", kif.press, kif.key_value);
      end
      last_digit = 4'd1;
   endtask

   task automatic test_repeat();
      int a, at, gaps, g1, g2;
      bit ok;
      gaps = 0; g1 = 0; g2 = 0;
      step(1);
      set_key(1, 0, 1'b1);
      exp_q.push_back({4'd1, 4'd4});
`ifdef KEY_REPEAT_EN
      exp_q.push_back({4'd1, 4'd4});
      exp_q.push_back({4'd1, 4'd4});
`endif
      wait_level(1, 1'b1, 60, a, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL repeat_press got 0 required 1"); end
      for (int i = 1; i < 1200; i++) begin
         @(negedge clk);
         if (!kif.press) begin
            gaps++;
            if (gaps == 1) g1 = cyc - a;
            if (gaps == 2) g2 = cyc - a;
         end
      end
      checks++;
      if (kif.key_value !== 4'd4) begin
         errors++; $display("FAIL repeat_key_value got %0d required 4", kif.key_value);
      end
`ifdef KEY_REPEAT_EN
      checks++;
      if (gaps != 2 || g1 != RC || g2 != 2 * RC) begin
         errors++; $display("FAIL repeat_gaps got n=%0d at %0d,%0d required n=2 at %0d,%0d",
                            gaps, g1, g2, RC, 2 * RC);
      end
`else
      checks++;
      if (gaps != 0) begin
         errors++; $display("FAIL repeat_no_gaps got %0d required 0", gaps);
      end
`endif
      step(1);
      set_key(1, 0, 1'b0);
      wait_level(1, 1'b0, 60, at, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL repeat_release got 1 required 0"); end
      step(10);
      last_digit = 4'd4;
   endtask

   task automatic test_reset_mid_hold();
      int at;
      bit ok;
      step(1);
      set_key(1, 1, 1'b1);
      exp_q.push_back({4'd1, 4'd5});
      wait_level(1, 1'b1, 60, at, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_hold_press got 0 required 1"); end
      step(5);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({kif.press, kif.start, kif.clear, kif.confirm, kif.key_value} !== 8'h00) begin
         errors++; $display("FAIL rst_hold_outputs got %h required 00",
                            {kif.press, kif.start, kif.clear, kif.confirm, kif.key_value});
      end
      checks++;
      if (kif.col_n !== 4'b1110) begin
         errors++; $display("FAIL rst_hold_col_n got %b required 1110", kif.col_n);
      end
      pressed = '0;
      last_digit = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (kif.col_n !== 4'b1101) begin
         errors++; $display("FAIL rst_hold_resume got %b required 1101", kif.col_n);
      end
      step(30);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_function_keys();
      test_two_keys();
      test_repeat();
      test_reset_mid_hold();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL missing_outputs got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
